// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the per-core caches, the arbiter and the shared RAM port.
// The master modport is the arbiter's view; slave is the surrounding caches + RAM.
interface mem_bus_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32
);
  logic [N_PORTS-1:0]        req_read;
  logic [N_PORTS-1:0]        req_write;
  logic [N_PORTS-1:0]        req_atomic;
  logic [N_PORTS*ADDR_W-1:0] req_addr;
  logic [N_PORTS*DATA_W-1:0] req_data_w;
  logic [N_PORTS-1:0]        port_wait;
  logic [DATA_W-1:0]         port_data_r;
  logic [N_PORTS-1:0]        grant;
  logic [N_PORTS-1:0]        snoop_valid;
  logic [ADDR_W-1:0]         snoop_addr;
  logic [DATA_W-1:0]         snoop_data;
  logic                      mem_read;
  logic                      mem_write;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_data_w;
  logic [DATA_W-1:0]         mem_data_r;
  logic                      mem_wait;

  modport master (
    input  req_read, req_write, req_atomic, req_addr, req_data_w, mem_data_r, mem_wait,
    output port_wait, port_data_r, grant, snoop_valid, snoop_addr, snoop_data,
           mem_read, mem_write, mem_addr, mem_data_w
  );

  modport slave (
    output req_read, req_write, req_atomic, req_addr, req_data_w, mem_data_r, mem_wait,
    input  port_wait, port_data_r, grant, snoop_valid, snoop_addr, snoop_data,
           mem_read, mem_write, mem_addr, mem_data_w
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin shared-RAM arbiter: one cache owns the RAM port for a whole burst,
// and completed atomic write beats are broadcast to the other caches as snoops.
module mem_bus_arbiter_lane (
  input  logic rd,
  input  logic wr,
  input  logic granted,
  input  logic mem_wait,
  output logic req,
  output logic stall
);
  assign req   = rd | wr;
  assign stall = granted ? mem_wait : req;
endmodule

module mem_bus_arbiter #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32
) (
  input logic               clk,
  input logic               rst,
  mem_bus_arbiter_if.master bus
);
  localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [N_PORTS-1:0] ONE = {{(N_PORTS-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                         state, state_nxt;
  logic [IW-1:0]                  rr_ptr, gidx, win_idx, cand;
  logic                           win_found, exit_burst, snoop_hit;
  logic [N_PORTS-1:0]             req, pw, grant_q, snoop_v;
  logic [N_PORTS-1:0][ADDR_W-1:0] addr_v;
  logic [N_PORTS-1:0][DATA_W-1:0] data_v;
  logic                           mem_rd, mem_wr;
  logic [ADDR_W-1:0]              mem_a, snoop_a;
  logic [DATA_W-1:0]              mem_d, snoop_d;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (int'(v) == N_PORTS - 1) ? '0 : v + 1'b1;
  endfunction

  assign addr_v = bus.req_addr;
  assign data_v = bus.req_data_w;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_lane
    mem_bus_arbiter_lane u_lane (
      .rd      (bus.req_read[i]),
      .wr      (bus.req_write[i]),
      .granted (grant_q[i]),
      .mem_wait(bus.mem_wait),
      .req     (req[i]),
      .stall   (pw[i])
    );
  end

  // Walk the ring starting at rr_ptr; the first requester seen wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    cand      = rr_ptr;
    for (int k = 0; k < N_PORTS; k++) begin
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (win_found) state_nxt = BUSY;
      BUSY: if (exit_burst) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write takes priority when a cache raises read and write together.
  always_comb begin
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    mem_a  = '0;
    mem_d  = '0;
    if (state == BUSY) begin
      mem_wr = bus.req_write[gidx];
      mem_rd = bus.req_read[gidx] & ~bus.req_write[gidx];
      mem_a  = addr_v[gidx];
      mem_d  = data_v[gidx];
    end
  end

  assign exit_burst = (state == BUSY) && !req[gidx];
  assign snoop_hit  = (state == BUSY) && mem_wr && bus.req_atomic[gidx] && !bus.mem_wait;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      grant_q <= '0;
      gidx    <= '0;
      rr_ptr  <= '0;
      snoop_v <= '0;
      snoop_a <= '0;
      snoop_d <= '0;
    end else begin
      if (state == IDLE && win_found) begin
        grant_q <= ONE << win_idx;
        gidx    <= win_idx;
      end else if (exit_burst) begin
        grant_q <= '0;
        rr_ptr  <= wrap_inc(gidx);
      end
      snoop_v <= snoop_hit ? ~(ONE << gidx) : '0;
      if (snoop_hit) begin
        snoop_a <= mem_a;
        snoop_d <= mem_d;
      end
    end

  assign bus.grant       = grant_q;
  assign bus.port_wait   = pw;
  assign bus.port_data_r = bus.mem_data_r;
  assign bus.snoop_valid = snoop_v;
  assign bus.snoop_addr  = snoop_a;
  assign bus.snoop_data  = snoop_d;
  assign bus.mem_read    = mem_rd;
  assign bus.mem_write   = mem_wr;
  assign bus.mem_addr    = mem_a;
  assign bus.mem_data_w  = mem_d;
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shared-RAM arbiter between N per-core caches and the single RAM port; sits directly downstream of each cache's RAM interface.
- Grants one cache at a time, round-robin, and holds the grant for the whole 16-word line burst.
- Muxes the granted cache's read/write/address/data onto RAM and returns per-port wait.
- Broadcasts completed atomic write beats to all other caches as snoop updates.

Parameters:
- N_PORTS, 4, number of cache ports (2..8)
- DATA_W, 32, data word width
- ADDR_W, 32, word address width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_read  in  N_PORTS  per-port RAM read request (cache ram_read)
- req_write  in  N_PORTS  per-port RAM write request (cache ram_write)
- req_atomic  in  N_PORTS  per-port atomic flag (cache cache_atomic_o)
- req_addr  in  N_PORTS*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W]
- req_data_w  in  N_PORTS*DATA_W  per-port write data, same packing
- port_wait  out  N_PORTS  per-port wait (cache ram_wait)
- port_data_r  out  DATA_W  read data, broadcast to all ports
- grant  out  N_PORTS  one-hot grant (cache arbiter_permit)
- snoop_valid  out  N_PORTS  per-port atomic update strobe (cache cache_atomic_i)
- snoop_addr  out  ADDR_W  address of the broadcast atomic beat
- snoop_data  out  DATA_W  data of the broadcast atomic beat
- mem_read  out  1  RAM read
- mem_write  out  1  RAM write
- mem_addr  out  ADDR_W  RAM address
- mem_data_w  out  DATA_W  RAM write data
- mem_data_r  in  DATA_W  RAM read data
- mem_wait  in  1  RAM busy; a beat completes in a cycle with (mem_read|mem_write) && !mem_wait

Behaviour:
- Reset values: grant, snoop_valid, snoop_addr, snoop_data = 0; rr_ptr = 0; state = IDLE. Reset mid-burst drops the grant immediately.
- port_wait, mem_* and port_data_r are combinational and follow the reset state: mem_read = mem_write = 0.
- req(i) = req_read[i] | req_write[i].
- State IDLE:
  - Search ports rr_ptr, rr_ptr+1, ... mod N_PORTS; the first i with req(i) wins.
  - Registered grant: grant[i] = 1 at the next edge; go to BUSY.
  - No request: stay IDLE.
- State BUSY, winner g:
  - mem_read = req_read[g] & ~req_write[g]; mem_write = req_write[g] (write wins if both are asserted).
  - mem_addr = req_addr[g]; mem_data_w = req_data_w[g].
  - Exit condition: req(g) = 0 in a cycle.
  - On exit: grant <= 0, rr_ptr <= (g+1) mod N_PORTS, go to IDLE.
  - Minimum one dead cycle between successive grants.
- port_wait[i]:
  - req(i) && !grant[i] -> 1;
  - grant[i] -> mem_wait;
  - otherwise 0.
- port_data_r = mem_data_r, unregistered.
- Grant latency: request at edge t, grant visible and RAM driven from cycle t+1, port_wait = 1 during cycle t.
- Atomic snoop:
  - Trigger: in BUSY, mem_write && req_atomic[g] && !mem_wait.
  - Next edge: snoop_valid <= all ones except bit g; snoop_addr <= mem_addr; snoop_data <= mem_data_w.
  - Otherwise snoop_valid <= 0; addr/data hold their last value.
  - Each completed atomic beat gives exactly one 1-cycle pulse, 1-cycle latency.
  - Back-to-back atomic beats give back-to-back pulses.
- Non-atomic writes and all reads never pulse snoop_valid.
- Fairness: a continuously requesting port waits at most N_PORTS-1 bursts.
- A requester that drops its request before being granted is simply skipped.

Test Plan:
- Single port 0 read burst, mem_wait = 0, 16 beats -> grant = 0001 one cycle after req; mem_addr follows port 0; port_wait[0] = 0 during BUSY; grant = 0 one cycle after req drop; rr_ptr = 1.
- Ports 0, 2, 3 request simultaneously from reset, each holding 16 cycles -> grant order 0001, 0100, 1000 with one idle cycle between; waiting ports see port_wait = 1 throughout.
- Port 1 granted, mem_wait high 3 cycles per beat -> port_wait[1] mirrors mem_wait exactly; the burst completes 16 beats in 64 cycles.
- Port 2 atomic write, addr 0x00001230, data 0xDEADBEEF, mem_wait = 0 -> next cycle snoop_valid = 1011 (N = 4), snoop_addr = 0x00001230, snoop_data = 0xDEADBEEF, one cycle only.
- Port 1 asserts read and write together, data 0x5 -> mem_write = 1, mem_read = 0.
- rst pulsed mid-burst of port 3 -> grant, snoop_valid and mem_write go 0 asynchronously; after release, port 0 requests and is granted first (rr_ptr = 0).
